action_gen: RTL and testbench

Prompt generator for the reflex game: it produces the per-round `action` code, the round `count` and the `level` play-window flag that the answer judge consumes. It also watches the judge's running `wrong_time` to end the game. It sits between the 100 ms tick divider and the judge/display logic. Each round it draws a pseudo-random direction, holds it for a timed answer window and inserts a blank gap. It ends the game on too many errors or on completing all rounds.

---
 rtl/action_gen.sv | 145 ++++++++++++++
 tb/tb_action_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/action_gen.sv
// action_gen: reflex-game prompt generator. Draws a pseudo-random direction per round,
// holds it for a timed answer window, inserts a blank gap, and ends the game on
// too many errors (loss) or after all rounds (win).
// Optional feature: define ACTION_GEN_SPEEDUP_EN to shrink the window by 2 ticks
// every 5 rounds, with a floor of 10 ticks.
module action_gen #(
    parameter int WINDOW_TICKS = 40,
    parameter int GAP_TICKS    = 5,
    parameter int TOTAL_ROUNDS = 30,
    parameter int MAX_WRONG    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] wrong_time,
    output logic       level,
    output logic [3:0] action,
    output logic [7:0] count,
    output logic       game_over,
    output logic       win
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

    state_t      state_q, state_d;
    logic [7:0]  tcnt_q, tcnt_d, base_q, base_d, count_q, count_d;
    logic [3:0]  action_q, action_d;
    logic        level_q, level_d, over_q, over_d, win_q, win_d;
    logic [15:0] lfsr_q;
    logic [7:0]  misses, tcnt_inc, win_len;
    logic        err, idle_like;

    assign misses    = wrong_time - base_q;
    assign err       = misses >= 8'(MAX_WRONG);
    assign tcnt_inc  = tcnt_q + 8'd1;
    assign idle_like = (state_q == IDLE) || (state_q == OVER);

`ifdef ACTION_GEN_SPEEDUP_EN
    logic [7:0] win_len_q, win_len_d;

    function automatic logic [7:0] win_for(input logic [7:0] c);
        logic [7:0] dec;
        dec = 8'd2 * (c / 8'd5);
        return (8'(WINDOW_TICKS) < dec + 8'd10) ? 8'd10 : 8'(WINDOW_TICKS) - dec;
    endfunction

    assign win_len = win_len_q;

    // Window length is latched at round entry so it stays fixed for the whole round.
    always_ff @(posedge clk) begin
        if (rst) win_len_q <= '0;
        else     win_len_q <= win_len_d;
    end
`else
    assign win_len = 8'(WINDOW_TICKS);
`endif

    // State, counters, outputs and the free-running LFSR (taps 16/14/13/11).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            base_q   <= '0;
            count_q  <= '0;
            action_q <= '0;
            level_q  <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
            lfsr_q   <= 16'hACE1;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            base_q   <= base_d;
            count_q  <= count_d;
            action_q <= action_d;
            level_q  <= level_d;
            over_q   <= over_d;
            win_q    <= win_d;
            lfsr_q   <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // Next state: start from IDLE/OVER, error limit outranks window/gap expiry.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        base_d   = base_q;
        count_d  = count_q;
        action_d = action_q;
        level_d  = level_q;
        over_d   = over_q;
        win_d    = win_q;
`ifdef ACTION_GEN_SPEEDUP_EN
        win_len_d = win_len_q;
`endif
        if (idle_like) begin
            if (start) begin
                base_d   = wrong_time;
                count_d  = '0;
                win_d    = 1'b0;
                over_d   = 1'b0;
                action_d = {2'b00, lfsr_q[1:0]};
                tcnt_d   = '0;
                level_d  = 1'b1;
                state_d  = SHOW;
`ifdef ACTION_GEN_SPEEDUP_EN
                win_len_d = win_for(8'd0);
`endif
            end
        end else if (err) begin
            state_d = OVER;
            over_d  = 1'b1;
            win_d   = 1'b0;
            level_d = 1'b0;
        end else if (tick) begin
            tcnt_d = tcnt_inc;
            if (state_q == SHOW && tcnt_inc == win_len) begin
                tcnt_d  = '0;
                count_d = count_q + 8'd1;
                level_d = 1'b0;
                state_d = GAP;
            end else if (state_q == GAP && tcnt_inc == 8'(GAP_TICKS)) begin
                tcnt_d = '0;
                if (count_q == 8'(TOTAL_ROUNDS)) begin
                    state_d = OVER;
                    over_d  = 1'b1;
                    win_d   = 1'b1;
                end else begin
                    action_d = {2'b00, lfsr_q[1:0]};
                    level_d  = 1'b1;
                    state_d  = SHOW;
`ifdef ACTION_GEN_SPEEDUP_EN
                    win_len_d = win_for(count_q);
`endif
                end
            end
        end
    end

    assign level     = level_q;
    assign action    = action_q;
    assign count     = count_q;
    assign game_over = over_q;
    assign win       = win_q;
endmodule

// File: tb/tb_action_gen.sv
// tb_action_gen: directed bench for action_gen (3-round game, default window build).
module tb_action_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] wrong_time = 8'd0;
    logic       level;
    logic [3:0] action;
    logic [7:0] count;
    logic       game_over;
    logic       win;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr, m_prev;

    always #5 clk = ~clk;

    action_gen #(
        .WINDOW_TICKS(40),
        .GAP_TICKS(5),
        .TOTAL_ROUNDS(3),
        .MAX_WRONG(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .start(start),
        .wrong_time(wrong_time),
        .level(level),
        .action(action),
        .count(count),
        .game_over(game_over),
        .win(win)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, reset to ACE1; m_prev is the value seen at the last edge.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_prev <= m_lfsr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input int gap);
        repeat (gap - 1) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hi, lo;
        logic [3:0] act;
        cyc();
        cyc();
        chk("rst_level", 32'(level), 0);
        chk("rst_action", 32'(action), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_win", 32'(win), 0);

        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_level", 32'(level), 1);
        chk("start_action", 32'(action), 1);
        chk("start_count", 32'(count), 0);
        chk("start_over", 32'(game_over), 0);

        for (int r = 0; r < 3; r++) begin
            act = action;
            hi = 0;
            for (int t = 1; t <= 40; t++) begin
                if (level) hi++;
                if (r == 1 && t == 10) begin
                    start = 1'b1;
                    cyc();
                    start = 1'b0;
                end
                tk(10);
            end
            chk("window_len", 32'(hi), 40);
            chk("window_fall", 32'(level), 0);
            chk("count_step", 32'(count), 32'(r + 1));
            chk("action_upper", 32'(action[3:2]), 0);
            lo = 0;
            for (int t = 1; t <= 5; t++) begin
                if (!level) lo++;
                if (t == 5) chk("action_hold", 32'(action), 32'(act));
                tk(10);
            end
            chk("gap_len", 32'(lo), 5);
            if (r < 2) begin
                chk("next_level", 32'(level), 1);
                chk("next_action", 32'(action), 32'({2'b00, m_prev[1:0]}));
            end else begin
                chk("win_over", 32'(game_over), 1);
                chk("win_flag", 32'(win), 1);
                chk("win_level", 32'(level), 0);
                chk("win_count", 32'(count), 3);
            end
        end
        repeat (3) tk(10);
        chk("over_frozen_count", 32'(count), 3);
        chk("over_frozen_flag", 32'(game_over), 1);
        chk("over_frozen_win", 32'(win), 1);

        wrong_time = 8'd7;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("err_start_level", 32'(level), 1);
        chk("err_start_over", 32'(game_over), 0);
        chk("err_start_win", 32'(win), 0);
        chk("err_start_action", 32'(action), 32'({2'b00, m_prev[1:0]}));
        repeat (10) tk(2);
        wrong_time = 8'd11;
        cyc();
        chk("err_miss4_level", 32'(level), 1);
        chk("err_miss4_over", 32'(game_over), 0);
        wrong_time = 8'd12;
        cyc();
        chk("err_over", 32'(game_over), 1);
        chk("err_win", 32'(win), 0);
        chk("err_level", 32'(level), 0);
        chk("err_count", 32'(count), 0);

        wrong_time = 8'd20;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (39) tk(2);
        chk("prio_pre_level", 32'(level), 1);
        wrong_time = 8'd25;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("prio_over", 32'(game_over), 1);
        chk("prio_win", 32'(win), 0);
        chk("prio_count", 32'(count), 0);
        chk("prio_level", 32'(level), 0);

        wrong_time = 8'd254;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("wrap_level", 32'(level), 1);
        repeat (3) tk(2);
        wrong_time = 8'd2;
        cyc();
        chk("wrap_miss4", 32'(game_over), 0);
        wrong_time = 8'd3;
        cyc();
        chk("wrap_over", 32'(game_over), 1);
        chk("wrap_win", 32'(win), 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (45) tk(2);
        repeat (20) tk(2);
        chk("mid_count", 32'(count), 1);
        chk("mid_level", 32'(level), 1);
        rst = 1'b1;
        tick = 1'b1;
        cyc();
        chk("mrst_level", 32'(level), 0);
        chk("mrst_action", 32'(action), 0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_over", 32'(game_over), 0);
        chk("mrst_win", 32'(win), 0);
        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b0;
        chk("restart_action", 32'(action), 1);
        chk("restart_level", 32'(level), 1);
        repeat (39) tk(2);
        chk("start_tick_ignored", 32'(level), 1);
        tk(2);
        chk("restart_fall", 32'(level), 0);
        chk("restart_count", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
